// File: rtl/pwm_thresh_loader_pkg.sv
// pwm_thresh_loader_pkg: shared constants and FSM encoding for the PWM
// threshold loader.
// Build option: PWM_THRESH_LOADER_READBACK_EN adds the READ (verify) state.
package pwm_thresh_loader_pkg;

  localparam int          NCHAN_DEF          = 24;
  localparam int          CHAN_W             = 5;   // channel index width, NCHAN <= 2**CHAN_W
  localparam int          REG_STRIDE         = 4;   // byte stride between channel registers
  localparam int          THRESH_W_DEF       = 16;
  localparam logic [15:0] DEFAULT_THRESH_DEF = 16'h8000;

`ifdef PWM_THRESH_LOADER_READBACK_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2,
    S_READ  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2
  } state_e;
`endif

  // Wrapping successor of a channel index.
  function automatic logic [CHAN_W-1:0] next_chan(input logic [CHAN_W-1:0] c, input int nchan);
    return (32'(c) == 32'(nchan - 1)) ? '0 : c + 1'b1;
  endfunction

endpackage

// File: rtl/pwm_thresh_loader_if.sv
// pwm_thresh_loader_if: Wishbone bus between the threshold loader (master)
// and the PWM threshold wrapper (slave). Signal suffixes are from the
// master's point of view.
//   wb_cyc_o/stb_o/we_o/adr_o/dat_o/sel_o : master -> slave
//   wb_dat_i/ack_i/err_i/rty_i            : slave  -> master
interface pwm_thresh_loader_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/pwm_thresh_loader_rr_pick.sv
// thresh_rr_pick: combinational round-robin picker.
//   dirty : per-channel pending flags
//   ptr   : search start (must be < NCHAN)
//   found : any dirty bit set
//   idx   : first dirty channel at or after ptr, wrapping NCHAN-1 -> 0
module thresh_rr_pick
  import pwm_thresh_loader_pkg::*;
#(
  parameter int NCHAN = NCHAN_DEF
)(
  input  logic [NCHAN-1:0]  dirty,
  input  logic [CHAN_W-1:0] ptr,
  output logic              found,
  output logic [CHAN_W-1:0] idx
);

  logic [CHAN_W:0]   sum;
  logic [CHAN_W-1:0] c;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    c     = '0;
    for (int i = 0; i < NCHAN; i++) begin
      sum = {1'b0, ptr} + (CHAN_W+1)'(i);
      if (sum >= (CHAN_W+1)'(NCHAN)) sum = sum - (CHAN_W+1)'(NCHAN);
      c = sum[CHAN_W-1:0];
      if (!found && dirty[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
  end

endmodule

// File: rtl/pwm_thresh_loader.sv
// pwm_thresh_loader: shadow bank of NCHAN thresholds with dirty bits, pushed
// to the PWM core one Wishbone write at a time (round robin, timeout,
// bounded retry, sticky abandon error).
// Build option: PWM_THRESH_LOADER_READBACK_EN -- verify each write with a
// read; mismatches are counted and the channel is re-marked dirty.
// Ports:
//   clk_i, rst_i (sync, active high)
//   thr_valid_i/thr_chan_i/thr_value_i : shadow write strobe
//   load_all_i : mark every channel dirty
//   err_clr_i  : clear err_o / err_chan_o
//   wb         : Wishbone master port (pwm_thresh_loader_if.master)
//   busy_o, err_o, err_chan_o, mismatch_cnt_o : status
module pwm_thresh_loader
  import pwm_thresh_loader_pkg::*;
#(
  parameter int                  NCHAN          = NCHAN_DEF,
  parameter int                  THRESH_W       = THRESH_W_DEF,
  parameter logic [31:0]         CHAN_BASE      = 32'h0000_0000,
  parameter logic [THRESH_W-1:0] DEFAULT_THRESH = THRESH_W'(DEFAULT_THRESH_DEF),
  parameter bit                  LOAD_ON_RESET  = 1'b1,
  parameter int                  TIMEOUT_CYC    = 255,
  parameter int                  MAX_RETRY      = 3
)(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                thr_valid_i,
  input  logic [CHAN_W-1:0]   thr_chan_i,
  input  logic [THRESH_W-1:0] thr_value_i,
  input  logic                load_all_i,
  input  logic                err_clr_i,
  pwm_thresh_loader_if.master wb,
  output logic                busy_o,
  output logic                err_o,
  output logic [CHAN_W-1:0]   err_chan_o,
  output logic [7:0]          mismatch_cnt_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  state_e              state_q, state_d;
  logic [NCHAN-1:0]    dirty_q, dirty_d;
  logic [THRESH_W-1:0] shadow_q [NCHAN];
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic [THRESH_W-1:0] val_q, val_d;
  logic [CHAN_W-1:0]   ptr_q, ptr_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [RTY_W-1:0]    retry_q, retry_d, retry_n;
  logic                err_q;
  logic [CHAN_W-1:0]   err_chan_q;

  logic                found;
  logic [CHAN_W-1:0]   pick_idx;
  logic                pick;
  logic                abandon;
  logic                term_fail;
  logic                thr_ok;

  thresh_rr_pick #(.NCHAN(NCHAN)) u_pick (
    .dirty (dirty_q),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick_idx)
  );

  assign thr_ok    = thr_valid_i && (32'(thr_chan_i) < 32'(NCHAN));
  assign term_fail = wb.wb_err_i || wb.wb_rty_i || (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign retry_n   = retry_q + 1'b1;

`ifdef PWM_THRESH_LOADER_READBACK_EN
  logic       rd_q, rd_d;      // retry target after GAP: 1 = READ, 0 = WRITE
  logic       mismatch;
  logic [7:0] mis_cnt_q;
`else
  logic       unused_rd;
  assign unused_rd = ^wb.wb_dat_i;
`endif

  // Next state / datapath
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    val_d   = val_q;
    ptr_d   = ptr_q;
    tmo_d   = '0;
    retry_d = retry_q;
    pick    = 1'b0;
    abandon = 1'b0;
`ifdef PWM_THRESH_LOADER_READBACK_EN
    rd_d     = rd_q;
    mismatch = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          pick    = 1'b1;
          chan_d  = pick_idx;
          val_d   = shadow_q[pick_idx];
          retry_d = '0;
          state_d = S_WRITE;
`ifdef PWM_THRESH_LOADER_READBACK_EN
          rd_d    = 1'b0;
`endif
        end
      end
      S_WRITE: begin
        // ack outranks err/rty in the same cycle
        if (wb.wb_ack_i) begin
          ptr_d = next_chan(chan_q, NCHAN);
`ifdef PWM_THRESH_LOADER_READBACK_EN
          retry_d = '0;
          rd_d    = 1'b1;
          state_d = S_READ;
`else
          state_d = S_IDLE;
`endif
        end else if (term_fail) begin
          state_d = S_GAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`ifdef PWM_THRESH_LOADER_READBACK_EN
      S_READ: begin
        if (wb.wb_ack_i) begin
          mismatch = (wb.wb_dat_i[THRESH_W-1:0] != val_q);
          state_d  = S_IDLE;
        end else if (term_fail) begin
          state_d = S_GAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
`endif
      S_GAP: begin
        retry_d = retry_n;
        if (retry_n < RTY_W'(MAX_RETRY)) begin
`ifdef PWM_THRESH_LOADER_READBACK_EN
          state_d = rd_q ? S_READ : S_WRITE;
`else
          state_d = S_WRITE;
`endif
        end else begin
          abandon = 1'b1;
          ptr_d   = next_chan(chan_q, NCHAN);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Dirty bits: sets are applied after the pick clear so they win.
  always_comb begin
    dirty_d = dirty_q;
    if (pick) dirty_d[pick_idx] = 1'b0;
    if (thr_ok) dirty_d[thr_chan_i] = 1'b1;
`ifdef PWM_THRESH_LOADER_READBACK_EN
    if (mismatch) dirty_d[chan_q] = 1'b1;
`endif
    if (load_all_i) dirty_d = '1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      dirty_q    <= LOAD_ON_RESET ? '1 : '0;
      chan_q     <= '0;
      val_q      <= '0;
      ptr_q      <= '0;
      tmo_q      <= '0;
      retry_q    <= '0;
      err_q      <= 1'b0;
      err_chan_q <= '0;
      for (int i = 0; i < NCHAN; i++) shadow_q[i] <= DEFAULT_THRESH;
    end else begin
      state_q <= state_d;
      dirty_q <= dirty_d;
      chan_q  <= chan_d;
      val_q   <= val_d;
      ptr_q   <= ptr_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      if (thr_ok) shadow_q[thr_chan_i] <= thr_value_i;
      // A new abandon outranks a same-cycle clear and becomes the first error.
      if (abandon) begin
        err_q <= 1'b1;
        if (!err_q || err_clr_i) err_chan_q <= chan_q;
      end else if (err_clr_i) begin
        err_q      <= 1'b0;
        err_chan_q <= '0;
      end
    end
  end

`ifdef PWM_THRESH_LOADER_READBACK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q      <= 1'b0;
      mis_cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      if (mismatch && mis_cnt_q != 8'hFF) mis_cnt_q <= mis_cnt_q + 8'd1;
    end
  end
  assign mismatch_cnt_o = mis_cnt_q;
`else
  assign mismatch_cnt_o = '0;
`endif

  // Bus outputs decode straight from state; address/data only driven while cyc is up.
  logic active;
`ifdef PWM_THRESH_LOADER_READBACK_EN
  assign active = (state_q == S_WRITE) || (state_q == S_READ);
`else
  assign active = (state_q == S_WRITE);
`endif

  assign wb.wb_cyc_o = active;
  assign wb.wb_stb_o = active;
  assign wb.wb_we_o  = (state_q == S_WRITE);
  assign wb.wb_adr_o = active ? CHAN_BASE + 32'(chan_q) * 32'(REG_STRIDE) : '0;
  assign wb.wb_dat_o = active ? 32'(val_q) : '0;
  assign wb.wb_sel_o = active ? 4'hF : 4'h0;

  assign busy_o     = (state_q != S_IDLE) || (|dirty_q);
  assign err_o      = err_q;
  assign err_chan_o = err_chan_q;

endmodule
